// File: rtl/hex_keypad.sv
// hex_keypad: scanned 4x4 hex keypad with debounce, one pulse per press and a four-digit history.
// Define HEX_KEYPAD_CLEAR_EN to add a synchronous 'clear' input that zeroes data and key_code.
module hex_keypad #(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic        clk,
    input  logic        reset,
`ifdef HEX_KEYPAD_CLEAR_EN
    input  logic        clear,
`endif
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [15:0] data,
    output logic [3:0]  key_code,
    output logic        key_valid
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    typedef enum logic [2:0] {SCAN, DEBOUNCE, ACCEPT, HELD, RELEASE} state_t;

    state_t           state;
    state_t           state_next;
    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [CNT_W-1:0] deb_cnt;
    logic             cnt_done;
    logic [1:0]       col_idx;
    logic [1:0]       key_row;
    logic [1:0]       key_col;
    logic [1:0]       rs_idx;
    logic             single_low;
    logic [3:0]       key_pattern;
    logic [3:0]       decoded;
    logic             col_advance;
    logic             latch_key;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             clear_req;

`ifdef HEX_KEYPAD_CLEAR_EN
    assign clear_req = clear;
`else
    assign clear_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick        = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign cnt_done    = (deb_cnt == CNT_W'(DEBOUNCE_TICKS - 1));
    assign key_pattern = ~(4'b0001 << key_row);
    assign col         = ~(4'b0001 << col_idx);

    // Only a single low row line identifies a key; ghosted multi-key patterns fall to default.
    always_comb begin
        single_low = 1'b1;
        rs_idx     = 2'd0;
        case (rs)
            4'b1110: rs_idx = 2'd0;
            4'b1101: rs_idx = 2'd1;
            4'b1011: rs_idx = 2'd2;
            4'b0111: rs_idx = 2'd3;
            default: single_low = 1'b0;
        endcase
    end

    always_comb begin
        case ({key_row, key_col})
            4'h0:    decoded = 4'h1;
            4'h1:    decoded = 4'h2;
            4'h2:    decoded = 4'h3;
            4'h3:    decoded = 4'hA;
            4'h4:    decoded = 4'h4;
            4'h5:    decoded = 4'h5;
            4'h6:    decoded = 4'h6;
            4'h7:    decoded = 4'hB;
            4'h8:    decoded = 4'h7;
            4'h9:    decoded = 4'h8;
            4'hA:    decoded = 4'h9;
            4'hB:    decoded = 4'hC;
            4'hC:    decoded = 4'hE;
            4'hD:    decoded = 4'h0;
            4'hE:    decoded = 4'hF;
            default: decoded = 4'hD;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SCAN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        col_advance = 1'b0;
        latch_key   = 1'b0;
        cnt_clear   = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            SCAN: begin
                if (tick) begin
                    if (single_low) begin
                        latch_key  = 1'b1;
                        cnt_clear  = 1'b1;
                        state_next = DEBOUNCE;
                    end else begin
                        col_advance = 1'b1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (rs == key_pattern) begin
                        cnt_inc = 1'b1;
                        if (cnt_done) state_next = ACCEPT;
                    end else begin
                        col_advance = 1'b1;
                        state_next  = SCAN;
                    end
                end
            end
            ACCEPT: state_next = HELD;
            HELD: begin
                if (tick && rs == 4'hF) begin
                    cnt_clear  = 1'b1;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (tick) begin
                    if (rs == 4'hF) begin
                        cnt_inc = 1'b1;
                        if (cnt_done) state_next = SCAN;
                    end else begin
                        state_next = HELD;
                    end
                end
            end
            default: state_next = SCAN;
        endcase
    end

    always_comb begin
        key_valid = (state == ACCEPT);
    end

    // The column stays frozen from detection until the release is confirmed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            col_idx <= 2'd0;
            key_row <= 2'd0;
            key_col <= 2'd0;
            deb_cnt <= '0;
        end else begin
            if (col_advance) col_idx <= col_idx + 2'd1;
            if (latch_key) begin
                key_row <= rs_idx;
                key_col <= col_idx;
            end
            if (cnt_clear) begin
                deb_cnt <= '0;
            end else if (cnt_inc) begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

    // Clear takes priority over a coincident accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data     <= 16'h0000;
            key_code <= 4'h0;
        end else if (clear_req) begin
            data     <= 16'h0000;
            key_code <= 4'h0;
        end else if (state == ACCEPT) begin
            data     <= {data[11:0], decoded};
            key_code <= decoded;
        end
    end
endmodule

// File: tb/tb_hex_keypad.sv
// tb_hex_keypad: randomized keypad presses against a scoreboard of expected digits.
// A mechanical keypad model closes row/column contacts; a monitor pops expectations on each key_valid.
module tb_hex_keypad;
    localparam int CLK_DIV        = 4;
    localparam int DEBOUNCE_TICKS = 3;

    typedef struct packed {
        logic [3:0]  code;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] data;
    logic [3:0]  key_code;
    logic        key_valid;
`ifdef HEX_KEYPAD_CLEAR_EN
    logic        clear;
`endif

    logic [3:0]  pressed [4];
    logic [3:0]  key_at [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                 4'h4, 4'h5, 4'h6, 4'hB,
                                 4'h7, 4'h8, 4'h9, 4'hC,
                                 4'hE, 4'h0, 4'hF, 4'hD};
    exp_t        exp_q [$];
    logic [15:0] model_data;
    int          checks;
    int          errors;

    hex_keypad #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) dut (
        .clk(clk),
        .reset(reset),
`ifdef HEX_KEYPAD_CLEAR_EN
        .clear(clear),
`endif
        .row(row),
        .col(col),
        .data(data),
        .key_code(key_code),
        .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    // A pressed switch pulls its row low whenever its column is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r] & ~col);
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic find_key(input int digit, output int r, output int c);
        r = 0;
        c = 0;
        for (int i = 0; i < 16; i++) begin
            if (key_at[i] == 4'(digit)) begin
                r = i / 4;
                c = i % 4;
            end
        end
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 4'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_data = 16'h0000;
        release_all();
        repeat (2) @(negedge clk);
        check_output("reset_col", 32'(col), 32'(4'b1110));
        check_output("reset_data", 32'(data), 32'h0);
        check_output("reset_key_code", 32'(key_code), 32'h0);
        check_output("reset_key_valid", 32'(key_valid), 32'h0);
        reset = 1'b1;
    endtask

    task automatic apply_stimulus(input int digit, input int hold_clks, input int blip_clks,
                                  input bit expect_key, input bit ghost);
        int         r;
        int         c;
        exp_t       e;
        logic [3:0] col_before;
        find_key(digit, r, c);
        if (expect_key) begin
            model_data = {model_data[11:0], 4'(digit)};
            e.code     = 4'(digit);
            e.data     = model_data;
            exp_q.push_back(e);
        end
        @(negedge clk);
        if (ghost) begin
            pressed[0][c] = 1'b1;
            pressed[2][c] = 1'b1;
        end else begin
            pressed[r][c] = 1'b1;
        end
        repeat (hold_clks) @(negedge clk);
        if (blip_clks > 0) begin
            pressed[r][c] = 1'b0;
            repeat (blip_clks) @(negedge clk);
            pressed[r][c] = 1'b1;
            repeat (4 * CLK_DIV) @(negedge clk);
        end
        release_all();
        repeat (8 * CLK_DIV) @(negedge clk);
        check_output("pending_keys", 32'(exp_q.size()), 32'h0);
        col_before = col;
        repeat (CLK_DIV) @(negedge clk);
        check_output("col_advance", 32'(col), 32'({col_before[2:0], col_before[3]}));
    endtask

    initial begin : monitor
        exp_t cur;
        bit   pending;
        pending = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    check_output("data_after_key", 32'(data), 32'(cur.data));
                    check_output("key_code", 32'(key_code), 32'(cur.code));
                    pending = 1'b0;
                end
                if (key_valid) begin
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_key_valid", 32'(key_valid), 32'h0);
                    end else begin
                        cur     = exp_q.pop_front();
                        pending = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin : stimulus
        logic [3:0] exp_col;
        logic [3:0] prev_col;
        int         kind;
        int         d;
        int         r;
        int         c;
        bit         found;
        logic [3:0] seq [5];
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        model_data = 16'h0000;
`ifdef HEX_KEYPAD_CLEAR_EN
        clear      = 1'b0;
`endif
        release_all();
        do_reset();

        // Idle scanning: the column rotates once per CLK_DIV clocks.
        exp_col = 4'b1110;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n % CLK_DIV == 0) exp_col = {exp_col[2:0], exp_col[3]};
            check_output("idle_col", 32'(col), 32'(exp_col));
        end
        check_output("idle_data", 32'(data), 32'h0);

        apply_stimulus(5, 20 * CLK_DIV, 0, 1'b1, 1'b0);

        do_reset();
        seq = '{4'h1, 4'h2, 4'h3, 4'hA, 4'hF};
        for (int i = 0; i < 5; i++) apply_stimulus(int'(seq[i]), 12 * CLK_DIV, 0, 1'b1, 1'b0);
        check_output("sequence_data", 32'(data), 32'h23AF);

        apply_stimulus(5, 2 * CLK_DIV, 0, 1'b0, 1'b0);
        apply_stimulus(4'hC, 15 * CLK_DIV, 0, 1'b0, 1'b1);

        // Press 'C' right as its column is driven, then reset while it is still debouncing.
        found    = 1'b0;
        prev_col = col;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (col == 4'b0111 && prev_col != 4'b0111) found = 1'b1;
            prev_col = col;
        end
        check_output("wait_col3", 32'(found), 32'h1);
        find_key(4'hC, r, c);
        pressed[r][c] = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        do_reset();
        repeat (10 * CLK_DIV) @(negedge clk);
        check_output("debounce_reset_data", 32'(data), 32'h0);

        for (int k = 0; k < 20; k++) begin
            kind = int'($urandom_range(0, 3));
            d    = int'($urandom_range(0, 15));
            case (kind)
                0:       apply_stimulus(d, int'($urandom_range(12, 25)) * CLK_DIV, 0, 1'b1, 1'b0);
                1:       apply_stimulus(d, 12 * CLK_DIV, int'($urandom_range(1, 2 * CLK_DIV)), 1'b1, 1'b0);
                2:       apply_stimulus(d, int'($urandom_range(1, 2 * CLK_DIV)), 0, 1'b0, 1'b0);
                default: apply_stimulus(d, 15 * CLK_DIV, 0, 1'b0, 1'b1);
            endcase
        end
        check_output("random_data", 32'(data), 32'(model_data));

`ifdef HEX_KEYPAD_CLEAR_EN
        begin : clear_tests
            exp_t e;
            bit   got;
            do_reset();
            seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h0};
            for (int i = 0; i < 4; i++) apply_stimulus(int'(seq[i]), 12 * CLK_DIV, 0, 1'b1, 1'b0);
            check_output("clear_before", 32'(data), 32'h1234);
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
            check_output("clear_data", 32'(data), 32'h0);
            check_output("clear_key_code", 32'(key_code), 32'h0);
            model_data = 16'h0000;
            e.code = 4'h0;
            e.data = 16'h0000;
            exp_q.push_back(e);
            find_key(7, r, c);
            pressed[r][c] = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 25 * CLK_DIV && !got; i++) begin
                @(negedge clk);
                if (key_valid) got = 1'b1;
            end
            clear = got;
            @(negedge clk);
            clear = 1'b0;
            check_output("clear_accept_pulse", 32'(got), 32'h1);
            release_all();
            repeat (8 * CLK_DIV) @(negedge clk);
            check_output("clear_accept_data", 32'(data), 32'h0);
        end
`endif

        check_output("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
